// File: rtl/cpu_trace_buffer.sv
// Trace capture beside the single-cycle CPU: circular buffer of {pc, ctrl} samples,
// stops a programmable number of samples after a PC trigger, then drains oldest-first.
module cpu_trace_buffer #(
    parameter int PC_WIDTH   = 16,
    parameter int CTRL_WIDTH = 9,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int DW        = PC_WIDTH + CTRL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [PC_WIDTH-1:0]   trig_pc,
    input  logic [AW:0]           post_cnt,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DW-1:0]         rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  wrapped,
    output logic [AW:0]           entries
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] MAXPOST = (AW+1)'(DEPTH-1);

    state_t                state_q;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           entries_q, remaining_q;
    logic                  triggered_q, wrapped_q, rd_valid_q;
    logic [DW-1:0]         rd_data_q;
    logic [PC_WIDTH-1:0]   last_pc_q;
    logic                  have_pc_q;
    logic [DW-1:0]         mem [DEPTH];

    logic                  qual, wr_en, wrap_nxt;
    logic [AW:0]           post_clamp;
    logic [AW-1:0]         rd_start;

    always_comb begin
        // mode 1: first sample after arm always qualifies, then only on a pc change
        qual       = !mode || !have_pc_q || (pc_in != last_pc_q);
        wr_en      = (state_q == ARMED || state_q == CAPTURE) && qual && !abort;
        post_clamp = (post_cnt > MAXPOST) ? MAXPOST : post_cnt;
        wrap_nxt   = wrapped_q || (entries_q == FULL);
        // oldest entry sits at the slot the final write advances wr_ptr to
        rd_start   = wrap_nxt ? wr_ptr_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {pc_in, ctrl_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            entries_q   <= '0;
            remaining_q <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            last_pc_q   <= '0;
            have_pc_q   <= 1'b0;
        end else if (abort) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (arm) begin
                    state_q     <= ARMED;
                    wr_ptr_q    <= '0;
                    entries_q   <= '0;
                    triggered_q <= 1'b0;
                    wrapped_q   <= 1'b0;
                    have_pc_q   <= 1'b0;
                end
                ARMED, CAPTURE: if (wr_en) begin
                    wr_ptr_q  <= wr_ptr_q + 1'b1;
                    last_pc_q <= pc_in;
                    have_pc_q <= 1'b1;
                    if (entries_q == FULL) wrapped_q <= 1'b1;
                    else                   entries_q <= entries_q + 1'b1;
                    if (state_q == ARMED) begin
                        if (pc_in == trig_pc) begin
                            triggered_q <= 1'b1;
                            remaining_q <= post_clamp;
                            if (post_clamp == '0) begin
                                state_q  <= READOUT;
                                rd_ptr_q <= rd_start;
                            end else begin
                                state_q  <= CAPTURE;
                            end
                        end
                    end else begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == (AW+1)'(1)) begin
                            state_q  <= READOUT;
                            rd_ptr_q <= rd_start;
                        end
                    end
                end
                READOUT: begin
                    // entries counts what is still to be loaded into the output register
                    if ((!rd_valid_q || rd_ready) && entries_q != '0) begin
                        rd_data_q  <= mem[rd_ptr_q];
                        rd_valid_q <= 1'b1;
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        entries_q  <= entries_q - 1'b1;
                    end else if (rd_valid_q && rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy      = (state_q == ARMED) || (state_q == CAPTURE);
    assign triggered = triggered_q;
    assign wrapped   = wrapped_q;
    assign entries   = entries_q;

endmodule
